opal_tx: RTL and testbench

OPAL_TX -- requirements
Module: opal_tx

---
 rtl/opal_tx_if.sv | 34 +++
 rtl/opal_tx.sv | 156 +++++++++++++++
 tb/tb_opal_tx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/opal_tx_if.sv
// OPAL transmitter bus: frame request and parallel variables in, serial clock,
// frame-valid strobe, per-lane data and frame status out.
interface opal_tx_if #(
    parameter int QTD_VARIABLES     = 16,
    parameter int OPAL_OUTPUT_WIDTH = 16
);
    logic                                       i_start;
    logic [QTD_VARIABLES*OPAL_OUTPUT_WIDTH-1:0] i_data;
    logic                                       o_clk;
    logic                                       o_enable;
    logic [QTD_VARIABLES-1:0]                   o_data;
    logic                                       o_busy;
    logic                                       o_done;

    modport master (
        input  i_start,
        input  i_data,
        output o_clk,
        output o_enable,
        output o_data,
        output o_busy,
        output o_done
    );

    modport slave (
        output i_start,
        output i_data,
        input  o_clk,
        input  o_enable,
        input  o_data,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/opal_tx.sv
// OPAL frame transmitter: shifts QTD_VARIABLES parallel variables out LSB first, one lane each.
// Optional feature: define OPAL_TX_AUTOSTART_EN for continuous back-to-back frames without i_start.
module opal_tx #(
    parameter int QTD_VARIABLES     = 16,
    parameter int OPAL_OUTPUT_WIDTH = 16,
    parameter int CLK_DIV           = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    opal_tx_if.master bus
);
    localparam int N  = QTD_VARIABLES;
    localparam int W  = OPAL_OUTPUT_WIDTH;
    localparam int BW = $clog2(W);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] HOLD_LAST  = PW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(W - 1);

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("opal_tx: CLK_DIV must be 2 or more");
        end
        if (W < 2) begin : g_bad_width
            $error("opal_tx: OPAL_OUTPUT_WIDTH must be 2 or more");
        end
        if (2 * CLK_DIV * (W + 1) >= 1500) begin : g_bad_timeout
            $error("opal_tx: frame length reaches the 1500-cycle receiver timeout");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_TAIL, S_GAP} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_phase;
    logic [PW-1:0]   w_phase_next;
    logic [BW-1:0]   r_bit_cnt;
    logic [BW-1:0]   w_bit_next;
    logic [N*W-1:0]  r_shadow;
    logic            w_load;
    logic            w_done_next;
    logic            w_phase_end;
    logic [N-1:0]    w_first_bits;
    logic [N-1:0]    w_cur_bits;
    logic [N-1:0]    w_data_next;
    logic            r_o_clk;
    logic            r_o_enable;
    logic            r_o_busy;
    logic            r_o_done;
    logic [N-1:0]    r_o_data;

    // First bit comes straight from i_data because the shadow is loaded on the same edge.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic [W-1:0] w_var;
            assign w_var            = r_shadow[gi*W +: W];
            assign w_cur_bits[gi]   = w_var[r_bit_cnt];
            assign w_first_bits[gi] = bus.i_data[gi*W];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_bit_next   = r_bit_cnt;
        w_load       = 1'b0;
        w_done_next  = 1'b0;
        w_phase_end  = (r_phase == PHASE_LAST);
        case (r_state)
            S_IDLE: begin
`ifdef OPAL_TX_AUTOSTART_EN
                w_state_next = S_LOW;
                w_load       = 1'b1;
`else
                if (bus.i_start) begin
                    w_state_next = S_LOW;
                    w_load       = 1'b1;
                end
`endif
            end
            S_LOW: begin
                if (w_phase_end) w_state_next = S_HIGH;
            end
            S_HIGH: begin
                if (w_phase_end) begin
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_next = S_TAIL;
                    end else begin
                        w_state_next = S_LOW;
                        w_bit_next   = r_bit_cnt + 1'b1;
                    end
                end
            end
            S_TAIL: begin
                if (w_phase_end) w_state_next = S_GAP;
            end
            S_GAP: begin
                if (w_phase_end) begin
                    w_done_next = 1'b1;
`ifdef OPAL_TX_AUTOSTART_EN
                    w_state_next = S_LOW;
                    w_load       = 1'b1;
`else
                    w_state_next = S_IDLE;
`endif
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_state_next != r_state) w_phase_next = '0;
        else if (r_state != S_IDLE)  w_phase_next = r_phase + 1'b1;
        if (w_load || w_state_next == S_IDLE) w_bit_next = '0;

        // Later bits wait half a phase after the o_clk fall so the receiver sees stable data.
        w_data_next = r_o_data;
        if (w_load)
            w_data_next = w_first_bits;
        else if (r_state == S_LOW && r_phase == HOLD_LAST)
            w_data_next = w_cur_bits;
        else if (w_state_next == S_GAP || w_state_next == S_IDLE)
            w_data_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_bit_cnt  <= '0;
            r_shadow   <= '0;
            r_o_clk    <= 1'b0;
            r_o_enable <= 1'b0;
            r_o_busy   <= 1'b0;
            r_o_done   <= 1'b0;
            r_o_data   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_phase    <= w_phase_next;
            r_bit_cnt  <= w_bit_next;
            if (w_load) r_shadow <= bus.i_data;
            r_o_clk    <= (w_state_next == S_HIGH);
            r_o_enable <= (w_state_next == S_LOW) || (w_state_next == S_HIGH) ||
                          (w_state_next == S_TAIL);
            r_o_busy   <= (w_state_next != S_IDLE);
            r_o_done   <= w_done_next;
            r_o_data   <= w_data_next;
        end
    end

    assign bus.o_clk    = r_o_clk;
    assign bus.o_enable = r_o_enable;
    assign bus.o_data   = r_o_data;
    assign bus.o_busy   = r_o_busy;
    assign bus.o_done   = r_o_done;
endmodule

// File: tb/tb_opal_tx.sv
// Bench for opal_tx: CLK_DIV=4 and CLK_DIV=2 instances checked cycle by cycle against a
// frame-timeline reference model, a checkpoint table, and a serial-lane decoder.
module tb_opal_tx;
    localparam int N  = 16;
    localparam int W  = 16;
    localparam int DW = N * W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    opal_tx_if #(.QTD_VARIABLES(N), .OPAL_OUTPUT_WIDTH(W)) bus0 ();
    opal_tx_if #(.QTD_VARIABLES(N), .OPAL_OUTPUT_WIDTH(W)) bus1 ();

    opal_tx #(.QTD_VARIABLES(N), .OPAL_OUTPUT_WIDTH(W), .CLK_DIV(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    opal_tx #(.QTD_VARIABLES(N), .OPAL_OUTPUT_WIDTH(W), .CLK_DIV(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        int   t;
        logic o_clk;
        logic o_enable;
        logic o_busy;
        logic o_done;
        int   bit_idx;   // -1 means lanes must be all zero
    } vec_t;

    vec_t tbl[15];
    int   checks = 0;
    int   errors = 0;

    task automatic chk_v(input string name, input logic [N+3:0] act, input logic [N+3:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s act={clk,en,busy,done,data}=%h exp=%h", name, act, exp_v);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            if (errors < 40) $display("FAIL %s act=%0d exp=%0d", name, act, exp_v);
        end
    endtask

    function automatic logic [N+3:0] get_out(input int sel);
        if (sel == 0) return {bus0.o_clk, bus0.o_enable, bus0.o_busy, bus0.o_done, bus0.o_data};
        return {bus1.o_clk, bus1.o_enable, bus1.o_busy, bus1.o_done, bus1.o_data};
    endfunction

    task automatic drive(input int sel, input logic start, input logic [DW-1:0] data);
        if (sel == 0) begin
            bus0.i_start = start;
            bus0.i_data  = data;
        end else begin
            bus1.i_start = start;
            bus1.i_data  = data;
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [N-1:0] lanes_at(input logic [DW-1:0] snap, input int b);
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = snap[k*W + b];
        return v;
    endfunction

    // Expected outputs t cycles after the start-accept edge, from the frame timeline:
    // 2W alternating LOW/HIGH phases of d cycles, then TAIL, then GAP, then idle with o_done.
    function automatic logic [N+3:0] ref_out(input int t, input int d, input logic [DW-1:0] snap,
                                             input bit held);
        int len, tt, p, ph, b;
        logic c, e, bz, dn;
        logic [N-1:0] dat;
        len = 2 * d * W + 2 * d;
        tt  = held ? (t % (len + 1)) : t;
        c = 1'b0; e = 1'b0; bz = 1'b0; dn = 1'b0; dat = '0;
        if (tt == len) begin
            dn = 1'b1;
        end else if (tt < len) begin
            bz = 1'b1;
            p  = tt / d;
            ph = tt % d;
            if (p < 2 * W) begin
                e = 1'b1;
                b = p / 2;
                c = ((p % 2) == 1);
                if (!c && b > 0 && ph < d / 2) b = b - 1;
                dat = lanes_at(snap, b);
            end else if (p == 2 * W) begin
                e   = 1'b1;
                dat = lanes_at(snap, W - 1);
            end
        end
        return {c, e, bz, dn, dat};
    endfunction

    task automatic run_frame(input int sel, input int d, input logic [DW-1:0] snap, input int tmax,
                             input bit held, input int disturb_t, input int reset_t,
                             input bit noise, input bit use_tbl, input string tag);
        int len, first_done, n_done, n_pulse, exp_done, err0;
        logic [N+3:0] act;
        logic [N+3:0] tv;
        logic prev_clk;
        logic [DW-1:0] dec;
        len = 2 * d * W + 2 * d;
        first_done = -1; n_done = 0; n_pulse = 0; exp_done = 0; prev_clk = 1'b0; dec = '0;
        err0 = errors;
        drive(sel, 1'b1, snap);
        @(negedge clk);
        if (!held) drive(sel, 1'b0, snap);
        for (int t = 0; t <= tmax; t++) begin
            act = get_out(sel);
            chk_v($sformatf("%s_t%0d", tag, t), act, ref_out(t, d, snap, held));
            if ((held && (t % (len + 1)) == len) || (!held && t == len)) exp_done++;
            if (act[N]) begin
                n_done++;
                if (first_done < 0) first_done = t;
            end
            if (t < len && act[N+3] && !prev_clk) begin
                if (n_pulse < W)
                    for (int k = 0; k < N; k++) dec[k*W + n_pulse] = act[k];
                n_pulse++;
            end
            prev_clk = act[N+3];
            if (use_tbl)
                for (int i = 0; i < 15; i++)
                    if (tbl[i].t == t) begin
                        tv = {tbl[i].o_clk, tbl[i].o_enable, tbl[i].o_busy, tbl[i].o_done,
                              (tbl[i].bit_idx < 0) ? {N{1'b0}} : lanes_at(snap, tbl[i].bit_idx)};
                        chk_v($sformatf("table_t%0d", t), act, tv);
                    end
            if (t == reset_t) begin
                rst_n = 1'b0;
                #1;
                chk_v({tag, "_async_reset"}, get_out(sel), '0);
                chk_i({tag, "_done_before_reset"}, n_done, 0);
                $display("frame %s sel=%0d reset at t=%0d new_errors=%0d", tag, sel, t,
                         errors - err0);
                return;
            end
            if (t == disturb_t) drive(sel, 1'b1, '1);
            else if (disturb_t >= 0 && t == disturb_t + 1) drive(sel, 1'b0, '1);
            else if (noise && t < len) drive(sel, ($urandom_range(0, 7) == 0), rand_data());
            else if (noise) drive(sel, 1'b0, rand_data());
            @(negedge clk);
        end
        chk_i({tag, "_done_count"}, n_done, exp_done);
        chk_i({tag, "_done_cycle"}, first_done, len);
        chk_i({tag, "_oclk_pulses"}, n_pulse, W);
        for (int k = 0; k < N; k++)
            chk_i($sformatf("%s_lane%0d", tag, k), int'(dec[k*W +: W]), int'(snap[k*W +: W]));
        $display("frame %s sel=%0d len=%0d done_at=%0d pulses=%0d new_errors=%0d",
                 tag, sel, len, first_done, n_pulse, errors - err0);
    endtask

    task automatic wait_idle(input int sel);
        int n;
        logic [N+3:0] o;
        n = 0;
        o = get_out(sel);
        while (o[N+1] !== 1'b0 && n < 400) begin
            @(negedge clk);
            o = get_out(sel);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL wait_idle act=busy after %0d cycles exp=idle", n);
        end
        repeat (2) @(negedge clk);
    endtask

    logic [DW-1:0] snap;

    initial begin
        tbl[0]  = '{0,   1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[1]  = '{3,   1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[2]  = '{4,   1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[3]  = '{7,   1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[4]  = '{8,   1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[5]  = '{9,   1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[6]  = '{10,  1'b0, 1'b1, 1'b1, 1'b0, 1};
        tbl[7]  = '{12,  1'b1, 1'b1, 1'b1, 1'b0, 1};
        tbl[8]  = '{121, 1'b0, 1'b1, 1'b1, 1'b0, 14};
        tbl[9]  = '{124, 1'b1, 1'b1, 1'b1, 1'b0, 15};
        tbl[10] = '{128, 1'b0, 1'b1, 1'b1, 1'b0, 15};
        tbl[11] = '{132, 1'b0, 1'b0, 1'b1, 1'b0, -1};
        tbl[12] = '{135, 1'b0, 1'b0, 1'b1, 1'b0, -1};
        tbl[13] = '{136, 1'b0, 1'b0, 1'b0, 1'b1, -1};
        tbl[14] = '{137, 1'b0, 1'b0, 1'b0, 1'b0, -1};

        rst_n = 1'b1;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_v("reset_dut0", get_out(0), '0);
        chk_v("reset_dut1", get_out(1), '0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_v("idle_dut0", get_out(0), '0);
        chk_v("idle_dut1", get_out(1), '0);

        for (int k = 0; k < N; k++) snap[k*W +: W] = 16'hA5A0 + 16'(k);
        run_frame(0, 4, snap, 140, 1'b0, -1, -1, 1'b0, 1'b1, "basic");
        run_frame(0, 4, rand_data(), 145, 1'b0, 50, -1, 1'b0, 1'b0, "ignore_start");

        run_frame(0, 4, snap, 140, 1'b0, -1, 70, 1'b0, 1'b0, "reset_mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_v("in_reset", get_out(0), '0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_v("post_reset_idle", get_out(0), '0);
        end
        run_frame(0, 4, snap, 140, 1'b0, -1, -1, 1'b0, 1'b0, "after_reset");

        run_frame(1, 2, snap, 72, 1'b0, -1, -1, 1'b0, 1'b0, "div2");

        run_frame(0, 4, snap, 2 * 137 + 3, 1'b1, -1, -1, 1'b0, 1'b0, "held");
        drive(0, 1'b0, snap);
        wait_idle(0);

        for (int r = 0; r < 4; r++) begin
            run_frame(0, 4, rand_data(), 140, 1'b0, -1, -1, 1'b1, 1'b0, $sformatf("rand_d4_%0d", r));
            run_frame(1, 2, rand_data(), 72, 1'b0, -1, -1, 1'b1, 1'b0, $sformatf("rand_d2_%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
